// File: rtl/mmu_ctx.sv
// -----------------------------------------------------------------------------
// mmu_ctx -- context-switching MMU / address decoder for a 6809 system.
//
// Sits between the 6809 address bus and the ROM/RAM/I/O chip selects. Virtual
// pages (top PAGE_BITS of the address) are translated to physical frames
// through one page table per context. Each page-table entry carries an
// invalid bit and a write-protect bit. A bounded stack of {io_mapped,
// rom_mapped} modes is pushed by the rising edge of BS (interrupt/reset vector
// fetch), so the kernel always runs with I/O and ROM mapped. Page faults latch
// their cause, virtual page and context. The kernel reads these back through
// the I/O window at $FExx.
//
// Ports:
//   i_eclk       6809 E clock; all state changes on its rising edge
//   i_reset      synchronous, active-high reset
//   i_rw         6809 R/W (1 = read)
//   i_addr[15:0] virtual address
//   i_data[7:0]  write data from the CPU
//   i_bs         6809 BS line
//   o_data[7:0]  register read data (status window $FEAx)
//   o_data_oe    high while o_data must drive the bus (E-high only)
//   romcs_n      ROM chip select
//   ramcs_n      RAM chip select, suppressed on a faulting access
//   dev_n[3:0]   device selects for $FE1x..$FE4x (bit 0 = $FE1x)
//   paddr        translated physical frame number
//   pgfault_n    one-E-cycle page-fault pulse toward NMI
//   fault_state  current state of the fault FSM, for observation
//
// Register window while I/O is mapped, selected by i_addr[7:4]:
//   1-4 device selects, 5 set rom_mapped of top entry from i_addr[0],
//   6 enter user mode (stack cleared to a single user entry),
//   7 write PTE in context ctx_sel, 8 pop mode stack,
//   9 write ctx_user (A0=0) or ctx_sel (A0=1), A read fault status.
// -----------------------------------------------------------------------------
module mmu_ctx #(
    parameter int NCTX        = 4,
    parameter int PAGE_BITS   = 3,
    parameter int FRAME_BITS  = 6,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  i_eclk,
    input  logic                  i_reset,
    input  logic                  i_rw,
    input  logic [15:0]           i_addr,
    input  logic [7:0]            i_data,
    input  logic                  i_bs,
    output logic [7:0]            o_data,
    output logic                  o_data_oe,
    output logic                  romcs_n,
    output logic                  ramcs_n,
    output logic [3:0]            dev_n,
    output logic [FRAME_BITS-1:0] paddr,
    output logic                  pgfault_n,
    output logic [1:0]            fault_state
);

    localparam int CTX_BITS = $clog2(NCTX);
    localparam int SP_BITS  = $clog2(STACK_DEPTH);
    localparam int PAGES    = 1 << PAGE_BITS;
    localparam int ENTRIES  = NCTX * PAGES;

    localparam logic [SP_BITS-1:0] SP_TOP = SP_BITS'(STACK_DEPTH - 1);

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_PULSE = 2'd1,
        F_WAIT  = 2'd2
    } fault_state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [SP_BITS-1:0]     sp;
    logic [STACK_DEPTH-1:0] io_stk;
    logic [STACK_DEPTH-1:0] rom_stk;
    logic [CTX_BITS-1:0]    ctx_user;
    logic [CTX_BITS-1:0]    ctx_sel;
    // Page tables, flattened: entry index is {context, virtual page}.
    logic [7:0]             pt [ENTRIES];
    fault_state_t           fstate;
    logic [PAGE_BITS-1:0]   fault_vpage;
    logic [CTX_BITS-1:0]    fault_ctx;
    logic                   wp_cause;
    logic                   inv_cause;
    logic                   ovf;
    logic                   prev_bs;

    // ---------------------------------------------------------------------
    // Combinational decode and translation
    // ---------------------------------------------------------------------
    logic                  io_cur;
    logic                  rom_cur;
    logic [PAGE_BITS-1:0]  vpage;
    logic [CTX_BITS-1:0]   act_ctx;
    logic [7:0]            pte;
    logic                  fault_cond;
    logic                  rom_sel;
    logic                  io_active;
    logic [3:0]            win;
    logic                  status_rd;
    logic                  push;
    logic [SP_BITS-1:0]    sp_inc;
    logic [7:0]            status_byte;

    assign io_cur  = io_stk[sp];
    assign rom_cur = rom_stk[sp];
    assign vpage   = i_addr[15:16-PAGE_BITS];
    // The kernel always translates through context 0.
    assign act_ctx = io_cur ? '0 : ctx_user;
    assign pte     = pt[{act_ctx, vpage}];

    // Only user-mode accesses can fault; the kernel sees everything.
    assign fault_cond = !io_cur && (pte[7] || (pte[6] && !i_rw));

    assign rom_sel   = (i_addr[15:8] == 8'hFF) ||
                       ((i_addr >= 16'h2000) && (i_addr <= 16'h7FFF) && rom_cur);
    assign io_active = (i_addr[15:8] == 8'hFE) && io_cur;
    assign win       = i_addr[7:4];
    assign status_rd = io_active && (win == 4'hA) && i_rw;

    // Only the first high cycle of BS counts as a push.
    assign push   = i_bs && !prev_bs;
    assign sp_inc = sp + 1'b1;

    assign status_byte = {wp_cause, inv_cause, ovf, 5'(fault_vpage)};

    assign romcs_n   = !(i_eclk && rom_sel);
    assign ramcs_n   = !(i_eclk && !rom_sel && !io_active && !fault_cond);
    assign paddr     = pte[FRAME_BITS-1:0];
    assign o_data_oe = i_eclk && status_rd;
    assign o_data    = !status_rd ? 8'h00 :
                       (i_addr[0] ? 8'(fault_ctx) : status_byte);
    assign fault_state = fstate;

    always_comb begin
        dev_n = 4'hF;
        for (int n = 0; n < 4; n++) begin
            if (i_eclk && io_active && (win == 4'(n + 1))) begin
                dev_n[n] = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Mode stack, control registers, page tables and fault FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge i_eclk) begin
        if (i_reset) begin
            sp          <= '0;
            io_stk      <= STACK_DEPTH'(1);
            rom_stk     <= STACK_DEPTH'(1);
            ctx_user    <= '0;
            ctx_sel     <= '0;
            fstate      <= F_IDLE;
            pgfault_n   <= 1'b1;
            fault_vpage <= '0;
            fault_ctx   <= '0;
            wp_cause    <= 1'b0;
            inv_cause   <= 1'b0;
            ovf         <= 1'b0;
            prev_bs     <= 1'b0;
            // Kernel context is an identity map; user contexts start empty.
            for (int i = 0; i < ENTRIES; i++) begin
                pt[i] <= (i < PAGES) ? 8'(i) : 8'h80;
            end
        end else begin
            prev_bs <= i_bs;

            // A BS push wins over any register-window action this cycle.
            if (push) begin
                if (sp == SP_TOP) begin
                    // Saturate: reuse the top entry and remember the overflow.
                    ovf          <= 1'b1;
                    io_stk[sp]   <= 1'b1;
                    rom_stk[sp]  <= 1'b1;
                end else begin
                    sp              <= sp_inc;
                    io_stk[sp_inc]  <= 1'b1;
                    rom_stk[sp_inc] <= 1'b1;
                end
            end else if (io_active) begin
                case (win)
                    4'h5: rom_stk[sp] <= i_addr[0];
                    4'h6: begin
                        sp         <= '0;
                        io_stk[0]  <= 1'b0;
                        rom_stk[0] <= 1'b0;
                    end
                    4'h7: if (!i_rw) pt[{ctx_sel, i_addr[PAGE_BITS-1:0]}] <= i_data;
                    4'h8: if (sp != '0) sp <= sp - 1'b1;
                    4'h9: begin
                        if (!i_rw) begin
                            if (i_addr[0]) ctx_sel  <= i_data[CTX_BITS-1:0];
                            else           ctx_user <= i_data[CTX_BITS-1:0];
                        end
                    end
                    default: ;
                endcase
            end

            // Fault FSM: one pulse per fault, then hold off further captures
            // until the kernel is back in control (I/O mapped).
            case (fstate)
                F_IDLE: begin
                    if (fault_cond) begin
                        fstate      <= F_PULSE;
                        pgfault_n   <= 1'b0;
                        fault_vpage <= vpage;
                        fault_ctx   <= act_ctx;
                        wp_cause    <= pte[6] && !i_rw;
                        inv_cause   <= pte[7];
                    end
                end
                F_PULSE: begin
                    fstate    <= F_WAIT;
                    pgfault_n <= 1'b1;
                end
                F_WAIT: begin
                    if (io_cur) fstate <= F_IDLE;
                end
                default: begin
                    fstate    <= F_IDLE;
                    pgfault_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
